packet_buffer: RTL and testbench
================================

PACKET_BUFFER -- requirements
Module: packet_buffer

Interface
REQ-001 SHALL have parameter PACKET_BUFFER_NUM_ENTRIES, default 8, number of packet reassembly entries (>=2).
REQ-002 SHALL have port nocclk  input  1  NoC clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port next_flit  input  types::flit_t  incoming flit; uses header.flittype, header.flit_id.flit_num and header.flit_id.packet_id.
REQ-005 SHALL have port next_flit_valid  input  1  next_flit valid.
REQ-006 SHALL have port next_flit_ready  output  1  buffer can accept next_flit this cycle.
REQ-007 SHALL have port transfered_packet_completed  input  1  one-cycle pulse: consumer has taken the presented packet.
REQ-008 SHALL have port transfered_packet  output  packet_types::packet_element_t  presented complete packet.
REQ-009 SHALL have port transfered_packet_valid  output  1  transfered_packet holds a complete packet.

Function
REQ-010 Each entry SHALL hold: used flag, is_complete, packet_id, timer, tail_index, and buffer[0..7] of flit_t.
REQ-011 Flit SHALL be accepted on a rising edge when next_flit_valid & next_flit_ready.
REQ-012 next_flit_ready SHALL be combinational: 1 if a used, incomplete entry has a matching packet_id, or any entry is free; else 0.
REQ-013 Accepted flit SHALL go to the used, incomplete entry with matching packet_id; otherwise allocate the lowest-index free entry (used=1, packet_id set, is_complete=0, timer=0, tail_index=0, buffer cleared to 0).
REQ-014 Flit SHALL be written to buffer[flit_num]; flit_num >= 8 SHALL be accepted and discarded.
REQ-015 On accepted TAIL flit: is_complete=1, tail_index=flit_num+1 (TAIL with flit_num 2 gives tail_index 3).
REQ-016 HEAD and BODY flits SHALL only be stored; all non-TAIL types are treated as BODY.
REQ-017 Entry timer SHALL reset to 0 on every accepted flit, increment by 1 each cycle while used and incomplete (saturating), and hold once complete.
REQ-018 transfered_packet_valid SHALL be 1 when any entry is used and complete, visible the cycle after the TAIL edge.
REQ-019 transfered_packet SHALL be the presented entry's contents; all zeros when valid=0.
REQ-020 The presented entry SHALL be the lowest-index complete entry, latched and held stable until transfered_packet_completed, even if other packets complete meanwhile.
REQ-021 transfered_packet_completed while valid=1 SHALL free the presented entry at that edge; ignored when valid=0.
REQ-022 Freeing and flit acceptance in the same cycle SHALL both take effect; a freed entry is allocatable from the next cycle.
REQ-023 All entries full with no packet_id match SHALL give next_flit_ready=0 and leave state unchanged.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear all entries (used=0, all fields 0), giving next_flit_ready=1, transfered_packet_valid=0 and transfered_packet=0; a partially received packet is discarded.

Configuration
REQ-025 With PACKET_BUFFER_TIMEOUT_EN defined, a used, incomplete entry whose timer reaches packet_types::PACKET_TIMEOUT SHALL be freed on the next edge.
REQ-026 Without PACKET_BUFFER_TIMEOUT_EN, the timer SHALL only count and saturate; incomplete entries are never freed automatically.

Structure
REQ-027 packet_types package SHALL define packet_element_t (is_complete, packet_id, timer, tail_index 4 bits, buffer[8]), PACKET_MAX_FLITS=8 and PACKET_TIMEOUT; types SHALL define flit_t and flittype (HEAD, BODY, TAIL).
REQ-028 Entry selection (match, free and complete finding) SHALL use one sub-module, packet_buffer_lowest_index: a lowest-set-bit priority encoder.

Verification
REQ-029 After reset -> next_flit_ready=1, transfered_packet_valid=0.
REQ-030 HEAD(pid0,num0), BODY(pid0,num1) on consecutive cycles -> ready=1, valid=0 after each; TAIL(pid0,num2) -> next cycle valid=1, is_complete=1, packet_id=0, timer=0, tail_index=3, buffer[0..2] equal the three flits, buffer[3..7]=0.
REQ-031 No completed pulse for 20 cycles after REQ-030 -> transfered_packet unchanged, ready=1.
REQ-032 Interleaved pid1/pid2 flits, pid2 TAIL first -> pid2 presented; completed pulse -> pid1 presented after its TAIL.
REQ-033 8 distinct incomplete HEADs, then HEAD pid9 -> ready=0; BODY to an existing pid -> ready=1.
REQ-034 Reset asserted mid-packet -> valid=0 immediately; a later TAIL alone gives a packet with only that flit stored.

Source files
------------

// File: rtl/packet_buffer_pkg.sv
// Flit and reassembled-packet types shared by packet_buffer and its testbench.
// Both packages live here because flit_t is consumed inside packet_element_t.
package types;
    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } flittype_t;

    typedef struct packed {
        logic [7:0] packet_id;
        logic [3:0] flit_num;
    } flit_id_t;

    typedef struct packed {
        flittype_t flittype;
        flit_id_t  flit_id;
    } header_t;

    typedef struct packed {
        header_t     header;
        logic [31:0] payload;
    } flit_t;
endpackage

package packet_types;
    localparam int         PACKET_MAX_FLITS = 8;
    localparam logic [7:0] PACKET_TIMEOUT   = 8'd100;

    typedef struct packed {
        logic                                is_complete;
        logic [7:0]                          packet_id;
        logic [7:0]                          timer;
        logic [3:0]                          tail_index;
        types::flit_t [PACKET_MAX_FLITS-1:0] buffer;
    } packet_element_t;
endpackage

// File: rtl/packet_buffer_lowest_index.sv
// Lowest-set-bit priority encoder used for match, free and complete entry lookup.
module packet_buffer_lowest_index #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/packet_buffer.sv
// Reassembles NoC flits into packets across a small pool of entries and presents
// completed packets one at a time. Optional macro PACKET_BUFFER_TIMEOUT_EN frees stale entries.
module packet_buffer
    import types::*;
    import packet_types::*;
#(
    parameter int PACKET_BUFFER_NUM_ENTRIES = 8
) (
    input  logic            nocclk,
    input  logic            rst_n,
    input  flit_t           next_flit,
    input  logic            next_flit_valid,
    output logic            next_flit_ready,
    input  logic            transfered_packet_completed,
    output packet_element_t transfered_packet,
    output logic            transfered_packet_valid
);

    localparam int         NE        = PACKET_BUFFER_NUM_ENTRIES;
    localparam int         IW        = $clog2(NE);
    localparam int         FW        = $clog2(PACKET_MAX_FLITS);
    localparam logic [3:0] MAX_NUM   = 4'(PACKET_MAX_FLITS);
    localparam logic [7:0] TIMER_MAX = '1;

    logic [NE-1:0]   used;
    packet_element_t entries [NE];
    logic            pres_valid;
    logic [IW-1:0]   pres_idx;

    logic [NE-1:0] match_req, free_req, complete_req, expire;
    logic          match_found, free_found, complete_found;
    logic [IW-1:0] match_idx, free_idx, complete_idx, cur_idx, tgt_idx;
    logic          accept, store;
    packet_element_t upd;

`ifdef PACKET_BUFFER_TIMEOUT_EN
    always_comb begin
        expire = '0;
        for (int i = 0; i < NE; i++) begin
            expire[i] = used[i] & ~entries[i].is_complete & (entries[i].timer == PACKET_TIMEOUT);
        end
    end
`else
    assign expire = '0;
`endif

    // An entry about to time out no longer accepts flits for its packet id.
    always_comb begin
        match_req    = '0;
        free_req     = '0;
        complete_req = '0;
        for (int i = 0; i < NE; i++) begin
            complete_req[i] = used[i] & entries[i].is_complete;
            free_req[i]     = ~used[i];
            match_req[i]    = used[i] & ~entries[i].is_complete & ~expire[i]
                            & (entries[i].packet_id == next_flit.header.flit_id.packet_id);
        end
    end

    packet_buffer_lowest_index #(.N(NE)) u_match (
        .req   (match_req),
        .found (match_found),
        .idx   (match_idx)
    );

    packet_buffer_lowest_index #(.N(NE)) u_free (
        .req   (free_req),
        .found (free_found),
        .idx   (free_idx)
    );

    packet_buffer_lowest_index #(.N(NE)) u_complete (
        .req   (complete_req),
        .found (complete_found),
        .idx   (complete_idx)
    );

    assign next_flit_ready         = match_found | free_found;
    assign accept                  = next_flit_valid & next_flit_ready;
    assign store                   = accept & (next_flit.header.flit_id.flit_num < MAX_NUM);
    assign tgt_idx                 = match_found ? match_idx : free_idx;
    assign cur_idx                 = pres_valid ? pres_idx : complete_idx;
    assign transfered_packet_valid = complete_found;
    assign transfered_packet       = complete_found ? entries[cur_idx] : '0;

    always_comb begin
        upd = '0;
        if (match_found) upd = entries[match_idx];
        upd.packet_id = next_flit.header.flit_id.packet_id;
        upd.timer     = '0;
        upd.buffer[next_flit.header.flit_id.flit_num[FW-1:0]] = next_flit;
        if (next_flit.header.flittype == TAIL) begin
            upd.is_complete = 1'b1;
            upd.tail_index  = next_flit.header.flit_id.flit_num + 4'd1;
        end
    end

    // Later assignments win: a flit write overrides the timer tick on its entry.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            used       <= '0;
            pres_valid <= 1'b0;
            pres_idx   <= '0;
            for (int i = 0; i < NE; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (expire[i]) begin
                    used[i]    <= 1'b0;
                    entries[i] <= '0;
                end else if (used[i] && !entries[i].is_complete && entries[i].timer != TIMER_MAX) begin
                    entries[i].timer <= entries[i].timer + 8'd1;
                end
            end
            if (store) begin
                used[tgt_idx]    <= 1'b1;
                entries[tgt_idx] <= upd;
            end
            if (complete_found && transfered_packet_completed) begin
                used[cur_idx]    <= 1'b0;
                entries[cur_idx] <= '0;
                pres_valid       <= 1'b0;
            end else if (complete_found) begin
                pres_valid <= 1'b1;
                pres_idx   <= cur_idx;
            end
        end
    end

endmodule

// File: tb/tb_packet_buffer.sv
// Scoreboard bench for packet_buffer: directed scenarios plus randomized flit traffic
// checked against a packet-level reference model.
module tb_packet_buffer;
    import types::*;
    import packet_types::*;

    localparam int NE = 8;

    logic            nocclk = 1'b0;
    logic            rst_n  = 1'b0;
    flit_t           next_flit;
    logic            next_flit_valid;
    logic            next_flit_ready;
    logic            transfered_packet_completed;
    packet_element_t transfered_packet;
    logic            transfered_packet_valid;

    packet_buffer #(.PACKET_BUFFER_NUM_ENTRIES(NE)) dut (
        .nocclk                      (nocclk),
        .rst_n                       (rst_n),
        .next_flit                   (next_flit),
        .next_flit_valid             (next_flit_valid),
        .next_flit_ready             (next_flit_ready),
        .transfered_packet_completed (transfered_packet_completed),
        .transfered_packet           (transfered_packet),
        .transfered_packet_valid     (transfered_packet_valid)
    );

    always #5 nocclk = ~nocclk;

    typedef struct packed {
        logic ready;
        logic valid;
    } status_t;

    int              n_tests = 0;
    int              n_fail  = 0;
    status_t         status_q [$];
    packet_element_t pkt_q [$];
    logic            last_ready;

    bit         m_used [NE];
    bit         m_comp [NE];
    logic [7:0] m_pid  [NE];
    logic [3:0] m_tail [NE];
    flit_t      m_buf  [NE][PACKET_MAX_FLITS];
    int         m_pres;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk(input flittype_t t, input int pid, input int num, input logic [31:0] d);
        flit_t f;
        f.header.flittype          = t;
        f.header.flit_id.packet_id = 8'(pid);
        f.header.flit_id.flit_num  = 4'(num);
        f.payload                  = d;
        return f;
    endfunction

    function automatic int m_find_match(input logic [7:0] pid);
        for (int e = 0; e < NE; e++)
            if (m_used[e] && !m_comp[e] && m_pid[e] == pid) return e;
        return -1;
    endfunction

    function automatic int m_find_free();
        for (int e = 0; e < NE; e++)
            if (!m_used[e]) return e;
        return -1;
    endfunction

    function automatic int m_presented();
        if (m_pres >= 0) return m_pres;
        for (int e = 0; e < NE; e++)
            if (m_used[e] && m_comp[e]) return e;
        return -1;
    endfunction

    function automatic bit m_ready(input flit_t f);
        return (m_find_match(f.header.flit_id.packet_id) >= 0) || (m_find_free() >= 0);
    endfunction

    function automatic packet_element_t m_pkt(input int e);
        packet_element_t p;
        p             = '0;
        p.is_complete = 1'b1;
        p.packet_id   = m_pid[e];
        p.tail_index  = m_tail[e];
        for (int k = 0; k < PACKET_MAX_FLITS; k++) p.buffer[k] = m_buf[e][k];
        return p;
    endfunction

    task automatic m_reset();
        for (int e = 0; e < NE; e++) begin
            m_used[e] = 0;
            m_comp[e] = 0;
            m_pid[e]  = '0;
            m_tail[e] = '0;
            for (int k = 0; k < PACKET_MAX_FLITS; k++) m_buf[e][k] = '0;
        end
        m_pres = -1;
    endtask

    task automatic m_step(input flit_t f, input bit fv, input bit comp);
        int p;
        bit rdy;
        int t;
        p   = m_presented();
        rdy = m_ready(f);
        if (fv && rdy && f.header.flit_id.flit_num < 4'd8) begin
            t = m_find_match(f.header.flit_id.packet_id);
            if (t < 0) begin
                t         = m_find_free();
                m_used[t] = 1;
                m_comp[t] = 0;
                m_tail[t] = '0;
                m_pid[t]  = f.header.flit_id.packet_id;
                for (int k = 0; k < PACKET_MAX_FLITS; k++) m_buf[t][k] = '0;
            end
            m_buf[t][int'(f.header.flit_id.flit_num)] = f;
            if (f.header.flittype == TAIL) begin
                m_comp[t] = 1;
                m_tail[t] = f.header.flit_id.flit_num + 4'd1;
            end
        end
        if (p >= 0 && comp) begin
            m_used[p] = 0;
            m_comp[p] = 0;
            m_pres    = -1;
        end else if (p >= 0) begin
            m_pres = p;
        end
    endtask

    // Drive one cycle of inputs, queue what the monitor should see, then advance the model.
    task automatic cycle(input flit_t f, input bit fv, input bit comp);
        status_t s;
        int      p;
        next_flit                   = f;
        next_flit_valid             = fv;
        transfered_packet_completed = comp;
        p       = m_presented();
        s.ready = m_ready(f);
        s.valid = (p >= 0);
        status_q.push_back(s);
        if (p >= 0) pkt_q.push_back(m_pkt(p));
        #1 last_ready = next_flit_ready;
        @(posedge nocclk);
        m_step(f, fv, comp);
        #1;
    endtask

    task automatic do_reset();
        rst_n                       = 1'b0;
        next_flit_valid             = 1'b0;
        transfered_packet_completed = 1'b0;
        #1;
        check("rst_valid", transfered_packet_valid, 1'b0);
        check("rst_ready", next_flit_ready, 1'b1);
        check("rst_packet", transfered_packet, '0);
        m_reset();
        @(posedge nocclk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        status_t         s;
        packet_element_t e;
        forever begin
            @(negedge nocclk);
            if (status_q.size() > 0) begin
                s = status_q.pop_front();
                check("mon_ready", next_flit_ready, s.ready);
                check("mon_valid", transfered_packet_valid, s.valid);
                if (transfered_packet_valid) begin
                    if (pkt_q.size() > 0) begin
                        e = pkt_q.pop_front();
                        check("mon_packet", transfered_packet, e);
                    end else begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL mon_packet: got valid packet %0h expected none", transfered_packet);
                    end
                end else begin
                    check("mon_packet_zero", transfered_packet, '0);
                end
            end
        end
    end

    initial begin : driver
        flit_t           idle, h0, b1, t2, f;
        packet_element_t e030, e034;
        idle                        = '0;
        next_flit                   = '0;
        next_flit_valid             = 1'b0;
        transfered_packet_completed = 1'b0;
        m_reset();
        #1;
        check("reset_ready", next_flit_ready, 1'b1);
        check("reset_valid", transfered_packet_valid, 1'b0);
        check("reset_packet", transfered_packet, '0);
        @(posedge nocclk);
        #1 rst_n = 1'b1;

        h0 = mk(HEAD, 0, 0, 32'hA0A0_0000);
        b1 = mk(BODY, 0, 1, 32'hA1A1_1111);
        t2 = mk(TAIL, 0, 2, 32'hA2A2_2222);
        e030             = '0;
        e030.is_complete = 1'b1;
        e030.tail_index  = 4'd3;
        e030.buffer[0]   = h0;
        e030.buffer[1]   = b1;
        e030.buffer[2]   = t2;
        cycle(h0, 1, 0);
        check("head_valid", transfered_packet_valid, 1'b0);
        cycle(b1, 1, 0);
        check("body_valid", transfered_packet_valid, 1'b0);
        cycle(t2, 1, 0);
        check("tail_valid", transfered_packet_valid, 1'b1);
        check("tail_packet", transfered_packet, e030);
        for (int i = 0; i < 20; i++) cycle(idle, 0, 0);
        check("hold_packet", transfered_packet, e030);
        check("hold_ready", last_ready, 1'b1);
        cycle(idle, 0, 1);
        check("freed_valid", transfered_packet_valid, 1'b0);

        cycle(mk(HEAD, 1, 0, 32'h1000), 1, 0);
        cycle(mk(HEAD, 2, 0, 32'h2000), 1, 0);
        cycle(mk(BODY, 1, 1, 32'h1001), 1, 0);
        cycle(mk(TAIL, 2, 1, 32'h2001), 1, 0);
        check("pid2_first", transfered_packet.packet_id, 8'd2);
        cycle(mk(TAIL, 1, 2, 32'h1002), 1, 0);
        cycle(idle, 0, 0);
        check("pid2_latched", transfered_packet.packet_id, 8'd2);
        cycle(idle, 0, 1);
        check("pid1_next_valid", transfered_packet_valid, 1'b1);
        check("pid1_next", transfered_packet.packet_id, 8'd1);
        cycle(idle, 0, 1);
        check("drained_valid", transfered_packet_valid, 1'b0);

        for (int i = 0; i < NE; i++) cycle(mk(HEAD, 10 + i, 0, 32'(i)), 1, 0);
        cycle(mk(HEAD, 9, 0, 32'h9), 1, 0);
        check("full_ready", last_ready, 1'b0);
        cycle(mk(BODY, 12, 1, 32'hC1), 1, 0);
        check("full_match_ready", last_ready, 1'b1);
        cycle(mk(TAIL, 13, 1, 32'hD1), 1, 0);
        check("pre_reset_valid", transfered_packet_valid, 1'b1);

        do_reset();
        f                = mk(TAIL, 5, 3, 32'hC3C3_C3C3);
        e034             = '0;
        e034.is_complete = 1'b1;
        e034.packet_id   = 8'd5;
        e034.tail_index  = 4'd4;
        e034.buffer[3]   = f;
        cycle(f, 1, 0);
        check("lone_tail", transfered_packet, e034);
        cycle(idle, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            f = mk(flittype_t'(2'($urandom_range(0, 2))), int'($urandom_range(0, 11)),
                   int'($urandom_range(0, 7)), $urandom);
            cycle(f, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
        end

        @(negedge nocclk);
        #1;
        check("status_q_empty", 32'(status_q.size()), 32'd0);
        check("pkt_q_empty", 32'(pkt_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
